// File: rtl/load_unit.sv
// Load unit: issues one or two aligned word reads per load request and returns
// the byte-lane aligned, sign/zero-extended result (or a fault) as a one-cycle pulse.
module load_unit #(
  parameter int XLEN           = 32,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reqValid,
  output logic            reqReady,
  input  logic [XLEN-1:0] reqAddr,
  input  logic [2:0]      loadCtrl,
  output logic            memReqValid,
  input  logic            memReqReady,
  output logic [XLEN-1:0] memAddr,
  input  logic            memRspValid,
  input  logic [XLEN-1:0] memRspData,
  output logic            respValid,
  output logic [XLEN-1:0] respData,
  output logic            loadFault
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t          state_r;
  logic [2:0]      ctrl_r;
  logic [OW-1:0]   offset_r;
  logic            cross_r;
  logic            fault_r;
  logic [XLEN-1:0] beat0_r;
  logic [XLEN-1:0] beat1_r;

  logic [4:0]      sizeBytes_s;
  logic [4:0]      span_s;
  logic            crossing_s;
  logic            illegal_s;
  logic [XLEN-1:0] raw_s;
  logic [XLEN-1:0] ext_s;

  // Request decode: access size, word crossing and illegal encodings
  always_comb begin
    sizeBytes_s = 5'd1 << loadCtrl[1:0];
    span_s      = 5'(reqAddr[OW-1:0]) + sizeBytes_s;
    crossing_s  = (span_s > 5'(NB));
    illegal_s   = (loadCtrl == 3'b111) ||
                  ((XLEN == 32) && ((loadCtrl == 3'b011) || (loadCtrl == 3'b110)));
  end

  // Lane alignment of the two-beat window, then sign/zero extension
  always_comb begin
    raw_s = XLEN'({beat1_r, beat0_r} >> {offset_r, 3'b000});
    case (ctrl_r)
      3'b000:  ext_s = XLEN'($signed(raw_s[7:0]));
      3'b001:  ext_s = XLEN'($signed(raw_s[15:0]));
      3'b010:  ext_s = XLEN'($signed(raw_s[31:0]));
      3'b011:  ext_s = raw_s;
      3'b100:  ext_s = XLEN'(raw_s[7:0]);
      3'b101:  ext_s = XLEN'(raw_s[15:0]);
      3'b110:  ext_s = XLEN'(raw_s[31:0]);
      default: ext_s = '0;
    endcase
  end

  // Request sequencing, beat capture and registered result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      reqReady    <= 1'b1;
      memReqValid <= 1'b0;
      memAddr     <= '0;
      respValid   <= 1'b0;
      respData    <= '0;
      loadFault   <= 1'b0;
      ctrl_r      <= 3'b000;
      offset_r    <= '0;
      cross_r     <= 1'b0;
      fault_r     <= 1'b0;
      beat0_r     <= '0;
      beat1_r     <= '0;
    end else begin
      respValid <= 1'b0;
      loadFault <= 1'b0;
      case (state_r)
        IDLE: begin
          if (reqValid) begin
            ctrl_r   <= loadCtrl;
            offset_r <= reqAddr[OW-1:0];
            cross_r  <= crossing_s;
            beat0_r  <= '0;
            beat1_r  <= '0;
            reqReady <= 1'b0;
            memAddr  <= {reqAddr[XLEN-1:OW], {OW{1'b0}}};
            if (illegal_s || (crossing_s && !MISALIGN_SPLIT)) begin
              fault_r <= 1'b1;
              state_r <= DONE;
            end else begin
              fault_r     <= 1'b0;
              memReqValid <= 1'b1;
              state_r     <= REQ0;
            end
          end
        end
        REQ0: begin
          if (memReqReady) begin
            memReqValid <= 1'b0;
            state_r     <= WAIT0;
          end
        end
        WAIT0: begin
          if (memRspValid) begin
            beat0_r <= memRspData;
            if (cross_r) begin
              memReqValid <= 1'b1;
              memAddr     <= memAddr + XLEN'(NB);
              state_r     <= REQ1;
            end else begin
              state_r <= DONE;
            end
          end
        end
        REQ1: begin
          if (memReqReady) begin
            memReqValid <= 1'b0;
            state_r     <= WAIT1;
          end
        end
        WAIT1: begin
          if (memRspValid) begin
            beat1_r <= memRspData;
            state_r <= DONE;
          end
        end
        DONE: begin
          respValid <= 1'b1;
          loadFault <= fault_r;
          respData  <= fault_r ? '0 : ext_s;
          reqReady  <= 1'b1;
          state_r   <= IDLE;
        end
        default: begin
          memReqValid <= 1'b0;
          reqReady    <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: three instances (RV32 split, RV32 fault-on-cross,
// RV64 split) share one byte-array memory responder with programmable delays.
`timescale 1ns/1ps
module tb_load_unit;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]  reqValid;
  logic [63:0] reqAddr;
  logic [2:0]  loadCtrl;
  logic        memReqReady;
  logic        memRspValid;
  logic [63:0] memRspData;

  logic [2:0]  reqReadyV, memReqValidV, respValidV, loadFaultV;
  logic [31:0] memAddrA, memAddrB, respDataA, respDataB;
  logic [63:0] memAddrC, respDataC;

  load_unit #(.XLEN(32), .MISALIGN_SPLIT(1'b1)) uSplit32 (
    .clk(clk), .rst(rst), .reqValid(reqValid[0]), .reqReady(reqReadyV[0]),
    .reqAddr(reqAddr[31:0]), .loadCtrl(loadCtrl), .memReqValid(memReqValidV[0]),
    .memReqReady(memReqReady), .memAddr(memAddrA), .memRspValid(memRspValid),
    .memRspData(memRspData[31:0]), .respValid(respValidV[0]), .respData(respDataA),
    .loadFault(loadFaultV[0]));

  load_unit #(.XLEN(32), .MISALIGN_SPLIT(1'b0)) uFault32 (
    .clk(clk), .rst(rst), .reqValid(reqValid[1]), .reqReady(reqReadyV[1]),
    .reqAddr(reqAddr[31:0]), .loadCtrl(loadCtrl), .memReqValid(memReqValidV[1]),
    .memReqReady(memReqReady), .memAddr(memAddrB), .memRspValid(memRspValid),
    .memRspData(memRspData[31:0]), .respValid(respValidV[1]), .respData(respDataB),
    .loadFault(loadFaultV[1]));

  load_unit #(.XLEN(64), .MISALIGN_SPLIT(1'b1)) uSplit64 (
    .clk(clk), .rst(rst), .reqValid(reqValid[2]), .reqReady(reqReadyV[2]),
    .reqAddr(reqAddr), .loadCtrl(loadCtrl), .memReqValid(memReqValidV[2]),
    .memReqReady(memReqReady), .memAddr(memAddrC), .memRspValid(memRspValid),
    .memRspData(memRspData), .respValid(respValidV[2]), .respData(respDataC),
    .loadFault(loadFaultV[2]));

  logic [1:0]  sel;
  logic        curReqReady, curMemReqValid, curRespValid, curFault;
  logic [63:0] curMemAddr, curRespData;

  always_comb begin
    case (sel)
      2'd0: begin
        curReqReady = reqReadyV[0]; curMemReqValid = memReqValidV[0];
        curRespValid = respValidV[0]; curFault = loadFaultV[0];
        curMemAddr = {32'h0, memAddrA}; curRespData = {32'h0, respDataA};
      end
      2'd1: begin
        curReqReady = reqReadyV[1]; curMemReqValid = memReqValidV[1];
        curRespValid = respValidV[1]; curFault = loadFaultV[1];
        curMemAddr = {32'h0, memAddrB}; curRespData = {32'h0, respDataB};
      end
      default: begin
        curReqReady = reqReadyV[2]; curMemReqValid = memReqValidV[2];
        curRespValid = respValidV[2]; curFault = loadFaultV[2];
        curMemAddr = memAddrC; curRespData = respDataC;
      end
    endcase
  end

  logic [7:0]  mem [0:16383];
  logic [63:0] reqLog [$];
  int          rdyDly, rspDly;
  bit          unstable;
  int          errors, checks;

  function automatic logic [63:0] memWord(input logic [63:0] a, input int nb);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < nb; k++) w[8*k +: 8] = mem[a[13:0] + 14'(k)];
    return w;
  endfunction

  task automatic setWord(input logic [63:0] a, input logic [63:0] w, input int nb);
    for (int k = 0; k < nb; k++) mem[a[13:0] + 14'(k)] = w[8*k +: 8];
  endtask

  function automatic logic [63:0] logAt(input int i);
    if (reqLog.size() > i) return reqLog[i];
    return '1;
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory responder: ready after rdyDly waiting cycles, response rspDly cycles after handshake
  initial begin : memProc
    bit hsPend, rspPend;
    int waitCnt, rspCnt;
    logic [63:0] hsAddr, firstAddr;
    hsPend = 1'b0; rspPend = 1'b0; waitCnt = 0; rspCnt = 0;
    hsAddr = '0; firstAddr = '0;
    memReqReady = 1'b0; memRspValid = 1'b0; memRspData = '0;
    forever begin
      @(negedge clk);
      memRspValid = 1'b0;
      if (hsPend) begin
        hsPend = 1'b0; rspPend = 1'b1; rspCnt = rspDly;
      end
      if (rspPend) begin
        if (rspCnt == 0) begin
          memRspValid = 1'b1;
          memRspData  = memWord(hsAddr, (sel == 2'd2) ? 8 : 4);
          rspPend     = 1'b0;
        end else begin
          rspCnt--;
        end
      end
      if (curMemReqValid && !rspPend) begin
        if (waitCnt == 0) firstAddr = curMemAddr;
        else if (curMemAddr != firstAddr) unstable = 1'b1;
        if (waitCnt >= rdyDly) begin
          memReqReady = 1'b1; hsPend = 1'b1; hsAddr = curMemAddr;
          reqLog.push_back(curMemAddr); waitCnt = 0;
        end else begin
          memReqReady = 1'b0; waitCnt++;
        end
      end else begin
        memReqReady = 1'b0; waitCnt = 0;
      end
    end
  end

  task automatic doLoad(input logic [1:0] s, input logic [63:0] a, input logic [2:0] c,
                        input int rd, input int rs,
                        output logic [63:0] data, output logic fault, output int lat);
    @(negedge clk);
    sel = s; rdyDly = rd; rspDly = rs; reqLog.delete(); unstable = 1'b0;
    checkVal("reqReady_before_accept", {63'h0, curReqReady}, 64'h1);
    reqAddr = a; loadCtrl = c; reqValid = 3'b001 << s;
    @(posedge clk); #1;
    reqValid = 3'b000;
    lat = -1; data = '0; fault = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (curRespValid) begin
        lat = i; data = curRespData; fault = curFault;
        break;
      end
    end
  endtask

  logic [63:0] d;
  logic        f;
  int          lat;
  bit          lateSeen;

  initial begin
    errors = 0; checks = 0; sel = 2'd0; reqValid = 3'b000; reqAddr = '0; loadCtrl = LB;
    rdyDly = 0; rspDly = 0; unstable = 1'b0; rst = 1'b1;
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_reqReady",    {63'h0, curReqReady},    64'h1);
    checkVal("rst_memReqValid", {63'h0, curMemReqValid}, 64'h0);
    checkVal("rst_respValid",   {63'h0, curRespValid},   64'h0);
    checkVal("rst_loadFault",   {63'h0, curFault},       64'h0);
    checkVal("rst_respData",    curRespData,             64'h0);
    checkVal("rst_memAddr",     curMemAddr,              64'h0);
    @(negedge clk); rst = 1'b0;

    // Byte loads, sign and zero extended
    setWord(64'h1000, 64'h80FF7F01, 4);
    doLoad(2'd0, 64'h1003, LB, 0, 0, d, f, lat);
    checkVal("lb_data", d, 64'hFFFFFF80);
    checkVal("lb_fault", {63'h0, f}, 64'h0);
    checkVal("lb_lat", 64'(lat), 64'd3);
    checkVal("lb_nreads", 64'(reqLog.size()), 64'd1);
    checkVal("lb_memAddr", logAt(0), 64'h1000);
    @(posedge clk); #1;
    checkVal("lb_pulse_end", {63'h0, curRespValid}, 64'h0);
    checkVal("lb_hold", curRespData, 64'hFFFFFF80);
    doLoad(2'd0, 64'h1003, LBU, 0, 0, d, f, lat);
    checkVal("lbu_data", d, 64'h00000080);

    // Halfword loads, including unaligned within one word
    setWord(64'h1000, 64'hBEEF1234, 4);
    doLoad(2'd0, 64'h1002, LH, 0, 0, d, f, lat);
    checkVal("lh_data", d, 64'hFFFFBEEF);
    doLoad(2'd0, 64'h1002, LHU, 0, 0, d, f, lat);
    checkVal("lhu_data", d, 64'h0000BEEF);
    doLoad(2'd0, 64'h1001, LH, 0, 0, d, f, lat);
    checkVal("lh_unal_data", d, 64'hFFFFEF12);
    checkVal("lh_unal_nreads", 64'(reqLog.size()), 64'd1);

    // Word-crossing LW split into two reads
    setWord(64'h1004, 64'hAABBCCDD, 4);
    setWord(64'h1008, 64'h11223344, 4);
    doLoad(2'd0, 64'h1006, LW, 0, 0, d, f, lat);
    checkVal("split_data", d, 64'h3344AABB);
    checkVal("split_lat", 64'(lat), 64'd5);
    checkVal("split_nreads", 64'(reqLog.size()), 64'd2);
    checkVal("split_addr0", logAt(0), 64'h1004);
    checkVal("split_addr1", logAt(1), 64'h1008);

    // Crossing without split, and illegal encodings, fault immediately
    doLoad(2'd1, 64'h1006, LW, 0, 0, d, f, lat);
    checkVal("nosplit_fault", {63'h0, f}, 64'h1);
    checkVal("nosplit_data", d, 64'h0);
    checkVal("nosplit_lat", 64'(lat), 64'd1);
    checkVal("nosplit_nreads", 64'(reqLog.size()), 64'd0);
    @(posedge clk); #1;
    checkVal("fault_clear", {63'h0, curFault}, 64'h0);
    doLoad(2'd1, 64'h1000, LD, 0, 0, d, f, lat);
    checkVal("ld32_fault", {63'h0, f}, 64'h1);
    checkVal("ld32_lat", 64'(lat), 64'd1);
    doLoad(2'd0, 64'h1000, 3'b111, 0, 0, d, f, lat);
    checkVal("ctrl111_fault", {63'h0, f}, 64'h1);
    checkVal("ctrl111_data", d, 64'h0);

    // Back-pressure on the request and a slow response
    doLoad(2'd0, 64'h1004, LW, 3, 4, d, f, lat);
    checkVal("slow_data", d, 64'hAABBCCDD);
    checkVal("slow_lat", 64'(lat), 64'd10);
    checkVal("slow_stable", {63'h0, unstable}, 64'h0);
    checkVal("slow_addr", logAt(0), 64'h1004);

    // Reset while waiting for a response; the late response must be ignored
    setWord(64'h2000, 64'h12345678, 4);
    @(negedge clk);
    sel = 2'd0; rdyDly = 0; rspDly = 6; reqLog.delete();
    reqAddr = 64'h2000; loadCtrl = LW; reqValid = 3'b001;
    @(posedge clk); #1;
    reqValid = 3'b000;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checkVal("midrst_reqReady",    {63'h0, curReqReady},    64'h1);
    checkVal("midrst_memReqValid", {63'h0, curMemReqValid}, 64'h0);
    checkVal("midrst_respData",    curRespData,             64'h0);
    checkVal("midrst_memAddr",     curMemAddr,              64'h0);
    @(negedge clk); rst = 1'b0;
    lateSeen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (curRespValid) lateSeen = 1'b1;
    end
    checkVal("late_rsp_ignored", {63'h0, lateSeen}, 64'h0);
    doLoad(2'd0, 64'h2000, LW, 0, 0, d, f, lat);
    checkVal("postrst_data", d, 64'h12345678);
    checkVal("postrst_lat", 64'(lat), 64'd3);

    // RV64: LWU/LW extension and a split LD checked against the byte array
    setWord(64'h10, 64'hFFFFFFFF_80000000, 8);
    doLoad(2'd2, 64'h10, LWU, 0, 0, d, f, lat);
    checkVal("lwu64_data", d, 64'h00000000_80000000);
    checkVal("lwu64_addr", logAt(0), 64'h10);
    doLoad(2'd2, 64'h10, LW, 0, 0, d, f, lat);
    checkVal("lw64_data", d, 64'hFFFFFFFF_80000000);
    for (int k = 0; k < 16; k++) mem[14'h18 + 14'(k)] = 8'(8'hA1 + 8'(k * 29));
    doLoad(2'd2, 64'h1C, LD, 0, 0, d, f, lat);
    checkVal("ld64_data", d, memWord(64'h1C, 8));
    checkVal("ld64_lat", 64'(lat), 64'd5);
    checkVal("ld64_addr0", logAt(0), 64'h18);
    checkVal("ld64_addr1", logAt(1), 64'h20);
    checkVal("ld64_fault", {63'h0, f}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
Sequential load path between the execute stage and a word-wide data memory port. It accepts one load request, issues one or two aligned memory reads over a valid/ready handshake, then byte-lane aligns and sign- or zero-extends the result. It is parametrised in data width (RV32/RV64) and can either split word-crossing accesses into two reads or raise a fault.

Parameters:
XLEN, 32, datapath and memory word width in bits; legal values are 32 and 64.
MISALIGN_SPLIT, 1, 1 = split word-crossing loads into two reads; 0 = fault on them.

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  asynchronous, active-high reset
reqValid  input  1  load request valid
reqReady  output  1  high only in IDLE; a request is accepted when reqValid&reqReady
reqAddr  input  XLEN  byte address
loadCtrl  input  3  000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU
memReqValid  output  1  memory read request
memReqReady  input  1  memory accepts the request
memAddr  output  XLEN  word-aligned address; low log2(XLEN/8) bits are always 0
memRspValid  input  1  read data valid; one response per accepted request, in order
memRspData  input  XLEN  little-endian read word
respValid  output  1  one-cycle pulse; result is valid
respData  output  XLEN  extended load result
loadFault  output  1  qualified by respValid; misaligned (no split) or illegal loadCtrl

Behaviour:
- Reset: state IDLE; memReqValid, respValid and loadFault are 0; respData and memAddr are 0; internal registers are cleared. Reset asserted mid-operation aborts the access immediately. Any memRspValid that arrives while in IDLE is ignored.
- Access size: 1, 2, 4 or 8 bytes. Offset is reqAddr mod (XLEN/8).
- Illegal loadCtrl: codes 111, or 011/110 when XLEN=32.
- Crossing: offset + size > XLEN/8. Unaligned accesses that stay within one word complete as a single read.
- Acceptance: on the accept edge the unit latches addr, loadCtrl, offset and crossing.
  - Illegal or (crossing & !MISALIGN_SPLIT): go to DONE with fault=1 and data=0. No memory request is issued.
  - Otherwise go to REQ0.
- REQ0: memReqValid=1, memAddr=word(addr). Hold valid and address stable until memReqReady. On handshake go to WAIT0.
- WAIT0: on memRspValid, latch beat0. If crossing, go to REQ1, otherwise go to DONE.
- REQ1 and WAIT1: same as REQ0/WAIT0 with memAddr = word(addr) + XLEN/8, wrapping modulo 2^XLEN. The response is latched as beat1, then go to DONE.
- DONE: respValid=1 for exactly one cycle, then go to IDLE. reqReady=0 in DONE, so back-to-back requests are separated by at least one idle cycle.
- Alignment: raw = {beat1, beat0} >> (offset*8), computed at 2*XLEN width. beat1 is 0 when the access does not cross.
- Extension:
  - LB, LH, LW: sign-extend from bit 7/15/31 of raw.
  - LBU, LHU, LWU: zero-extend.
  - LD: raw[63:0].
  - LW at XLEN=32 is raw[31:0] with no extension.
- respData is registered and holds its value until the next DONE. loadFault is 0 whenever respValid=0.
- memRspValid in REQ0 or REQ1 is a protocol violation and is ignored.
- Latency: zero-wait memory (ready=1, response on the next cycle) gives respValid 3 cycles after accept, or 5 cycles if split. A fault gives respValid 1 cycle after accept.

Test Plan:
1. XLEN=32. LB at 0x1003, word@0x1000 = 0x80FF7F01 -> memAddr 0x1000, respData 0xFFFFFF80, loadFault=0. LBU at the same address -> 0x00000080.
2. LH, then LHU, at 0x1002 with word 0xBEEF1234 -> 0xFFFFBEEF, then 0x0000BEEF. LH at 0x1001 (in-word unaligned) -> 0xFFFFEF12 from a single read.
3. MISALIGN_SPLIT=1. LW at 0x1006, word@0x1004 = 0xAABBCCDD, word@0x1008 = 0x11223344 -> reads 0x1004 then 0x1008, respData 0x3344AABB, respValid 5 cycles after accept with zero-wait memory.
4. MISALIGN_SPLIT=0, same LW -> memReqValid never asserts; respValid 1 cycle after accept with loadFault=1 and respData 0. loadCtrl=011 at XLEN=32 -> same fault response.
5. memReqReady held low for 3 cycles in REQ0 -> memReqValid and memAddr stay stable; memRspValid delayed 4 cycles -> respValid follows 1 cycle after the response.
6. Assert rst in WAIT0 -> next edge in IDLE with reqReady=1 and all outputs at reset values. A late memRspValid is ignored. A new LW at 0x2000 of word 0x12345678 then returns 0x12345678.
7. XLEN=64. LWU at 0x10 of word 0xFFFFFFFF_80000000 -> 0x00000000_80000000. LD at 0x1C splits across two reads, and the result is checked against a byte-array model.
